// File: rtl/seven_seg_display_arbiter.sv
// rtl/seven_seg_display_arbiter.sv - round-robin owner arbitration with minimum hold for the shared 3-digit display
module seven_seg_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2**22,
    parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1),
    parameter int IDW         = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [12*NUM_REQ-1:0]   value,
    output logic [NUM_REQ-1:0]      grant,
    output logic [IDW-1:0]          owner_id,
    output logic                    busy,
    output logic                    switch_pulse,
    output logic [3:0]              digitL,
    output logic [3:0]              digitM,
    output logic [3:0]              digitR
);

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDW-1:0]       owner_q, owner_d;
    logic                 busy_q, busy_d;
    logic                 pulse_q, pulse_d;
    logic [11:0]          digits_q, digits_d;
    logic [HOLD_W-1:0]    cnt_q, cnt_d;

    logic [11:0]          val_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   cand;
    logic [IDW-1:0]       idx;
    logic [IDW-1:0]       pick;
    logic                 found;
    logic                 owner_live;
    logic                 take;
    logic                 go_idle;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            val_arr[i] = value[12*i +: 12];
        end
    end

    // Search downward so the candidate closest after owner_q is the last one written.
    // While idle grant_q is zero, so the previous owner itself is eligible on wrap-around.
    always_comb begin
        cand  = req & ~grant_q;
        found = 1'b0;
        pick  = owner_q;
        idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDW'((int'(owner_q) + i) % NUM_REQ);
            if (cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign owner_live = req[owner_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        pulse_d  = 1'b0;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        go_idle  = 1'b0;

        unique case (state_q)
            IDLE: take = found;
            HOLD, OPEN: begin
                if (!owner_live) begin
                    take    = found;
                    go_idle = !found;
                end else if (state_q == OPEN) begin
                    take = found;
                end else begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - HOLD_W'(1);
                    if (cnt_q <= HOLD_W'(1)) state_d = OPEN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            grant_d  = NUM_REQ'(1) << pick;
            owner_d  = pick;
            busy_d   = 1'b1;
            pulse_d  = 1'b1;
            digits_d = val_arr[pick];
            cnt_d    = HOLD_W'(HOLD_CYCLES - 1);
            state_d  = (HOLD_CYCLES == 1) ? OPEN : HOLD;
        end else if (go_idle) begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
        end else if (state_q != IDLE) begin
            digits_d = val_arr[owner_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= IDW'(NUM_REQ - 1);
            busy_q   <= 1'b0;
            pulse_q  <= 1'b0;
            digits_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            pulse_q  <= pulse_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant        = grant_q;
    assign owner_id     = owner_q;
    assign busy         = busy_q;
    assign switch_pulse = pulse_q;
    assign digitL       = digits_q[11:8];
    assign digitM       = digits_q[7:4];
    assign digitR       = digits_q[3:0];

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// tb/tb_seven_seg_display_arbiter.sv - scoreboard bench for the display arbiter
module tb_seven_seg_display_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [12*N-1:0]   value;
    logic [N-1:0]      grant;
    logic [1:0]        owner_id;
    logic              busy;
    logic              switch_pulse;
    logic [3:0]        digitL, digitM, digitR;

    seven_seg_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .value(value),
        .grant(grant), .owner_id(owner_id), .busy(busy),
        .switch_pulse(switch_pulse), .digitL(digitL), .digitM(digitM), .digitR(digitR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        int           owner;
        logic         busy;
        logic         pulse;
        logic [11:0]  dig;
    } exp_t;

    exp_t exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference: owner tenure counted in whole cycles since grant.
    int          m_owner;
    int          m_held;
    bit          m_busy;
    bit          m_pulse;
    logic [11:0] m_dig;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total_cnt++;
        if (act !== req_v) $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req_v, $time);
        else pass_cnt++;
    endtask

    function automatic logic [11:0] slot(input logic [12*N-1:0] v, input int i);
        logic [12*N-1:0] t;
        t = v >> (12 * i);
        return t[11:0];
    endfunction

    function automatic int rr(input logic [N-1:0] r, input int from, input bit excl);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (from + i) % N;
            if (r[c] && !(excl && c == from)) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = N - 1;
        m_held  = 0;
        m_busy  = 0;
        m_pulse = 0;
        m_dig   = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [12*N-1:0] v);
        int w;
        m_pulse = 0;
        if (!m_busy) begin
            w = rr(r, m_owner, 0);
        end else if (!r[m_owner]) begin
            w = rr(r, m_owner, 1);
            if (w < 0) m_busy = 0;
        end else begin
            w = (m_held + 1 >= H) ? rr(r, m_owner, 1) : -1;
            if (w < 0 && m_held < H) m_held++;
        end
        if (w >= 0) begin
            m_owner = w;
            m_busy  = 1;
            m_held  = 0;
            m_pulse = 1;
        end
        if (m_busy) m_dig = slot(v, m_owner);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [12*N-1:0] v);
        exp_t e;
        @(negedge clk);
        req   = r;
        value = v;
        model_edge(r, v);
        e.grant = m_busy ? (N'(1) << m_owner) : '0;
        e.owner = m_owner;
        e.busy  = m_busy;
        e.pulse = m_pulse;
        e.dig   = m_dig;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_pulse"}, 32'(switch_pulse), 32'(0));
        chk({tag, "_owner"}, 32'(owner_id), 32'(N - 1));
        chk({tag, "_digits"}, 32'({digitL, digitM, digitR}), 32'(0));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant", 32'(grant), 32'(e.grant));
                chk("owner_id", 32'(owner_id), 32'(e.owner));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("switch_pulse", 32'(switch_pulse), 32'(e.pulse));
                chk("digits", 32'({digitL, digitM, digitR}), 32'(e.dig));
            end
        end
    end

    initial begin : driver
        logic [N-1:0]    r;
        logic [12*N-1:0] v;
        reset_n = 1'b0;
        req     = '0;
        value   = '0;
        model_reset();
        #17;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        step(4'b0001, 48'h000_000_000_ABC);
        for (int i = 0; i < 10; i++) step(4'b0101, 48'h000_DEF_000_ABC);
        for (int i = 0; i < 20; i++) step(4'b1111, {$urandom, $urandom});
        for (int i = 0; i < 3; i++)  step(4'b0000, 48'h0);
        step(4'b0010, 48'h333_222_111_000);
        step(4'b1010, 48'h333_222_111_000);
        step(4'b1000, 48'h777_666_555_444);
        step(4'b1000, 48'h999_666_555_444);
        for (int i = 0; i < 3; i++)  step(4'b0000, {$urandom, $urandom});
        for (int i = 0; i < 8; i++)  step(4'b0001, 48'h000_000_000_123);
        for (int i = 0; i < 4; i++)  step(4'b0001, 48'h000_000_000_456);

        step(4'b0000, 48'h0);
        step(4'b0100, 48'h000_5A5_000_000);
        step(4'b0100, 48'h000_5A5_000_000);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        req = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(4'b1111, 48'h444_333_222_111);

        r = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) r = N'($urandom_range(0, 15));
            v = {16'($urandom), 32'($urandom)};
            step(r, v);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
